mux_tree_pipe: RTL and testbench
================================

// Module: mux_tree_pipe
// PURPOSE
//   Parametrised N:1 multiplexer built as a binary tree of 2:1 stages, with a
//   register after every tree level and valid/ready handshakes on input and output.
//   Selects one of N WIDTH-bit channels per accepted transfer.
//   Replaces flat combinational muxes on wide or high-fanin select paths in
//   datapath blocks that need timing closure and backpressure.
// PARAMETERS
//   WIDTH   8   data bits per channel (>=1)
//   N       4   number of input channels; power of two, >=2
//   SEL_W   $clog2(N)   select width and tree depth (LEVELS); derived, do not override
// PORTS
//   clk        in   1          single clock; all state updates on the rising edge
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          din/sel are valid this cycle
//   in_ready   out  1          block accepts a transfer this cycle (in_valid & in_ready)
//   sel        in   SEL_W      channel index, captured with the transfer
//   din        in   N*WIDTH    flattened channels; channel i = din[i*WIDTH +: WIDTH]
//   out_valid  out  1          dout/out_sel are valid
//   out_ready  in   1          consumer accepts (out_valid & out_ready)
//   dout       out  WIDTH      selected channel data
//   out_sel    out  SEL_W      sel value that produced dout
// BEHAVIOUR
//   - Reset (rst_n low, async assert, sync release on clk): all stage valids=0,
//     all data and carried-select registers=0; out_valid=0, dout=0, out_sel=0.
//     in_ready=1 in the first cycle after release.
//   - Stage k (k=0..SEL_W-1) holds N>>(k+1) lanes of WIDTH bits, one valid bit,
//     and the full sel value. Stage k lane j = sel[k] ? prev[2j+1] : prev[2j],
//     where prev for k=0 is din; sel bit 0 (LSB) resolves the first level.
//   - Last stage drives dout/out_valid/out_sel directly (registered outputs).
//   - Latency: an accepted transfer appears at the output exactly SEL_W cycles
//     later when no stall occurs. Throughput: one transfer per cycle.
//   - Advance rule: adv[SEL_W-1] = !v[SEL_W-1] | out_ready;
//     adv[k] = !v[k] | adv[k+1]; in_ready = adv[0]. A stage loads from its
//     predecessor when adv[k]=1 (valid loads 0 if predecessor empty, i.e.
//     bubbles propagate and are squeezed out); it holds all contents when adv[k]=0.
//   - in_ready depends combinationally on out_ready (ready chain, no skid);
//     the ready path must not depend on in_valid.
//   - Capacity: SEL_W transfers in flight. With out_ready=0, exactly SEL_W
//     transfers are accepted, then in_ready=0 until out_ready returns.
//   - Simultaneous accept and output pop in one cycle: both occur, no loss.
//   - Transfers leave in acceptance order; none dropped or duplicated.
//   - in_valid=0: din/sel are ignored; stage contents are don't-care but must be
//     held stable while their valid is 1 and the stage is stalled.
//   - dout/out_sel stable while out_valid=1 and out_ready=0.
//   - Reset mid-operation: all in-flight transfers are discarded immediately;
//     out_valid falls asynchronously.
//   - sel is always in range (N is a power of two); no error condition exists.
// TESTING (N=4, WIDTH=8 unless stated; din written ch3..ch0)
//   1 Reset: rst_n=0 -> out_valid=0, dout=8'h00, out_sel=0; after release in_ready=1.
//   2 Latency: din={DD,CC,BB,AA}, sel=2, one-cycle in_valid, out_ready=1 ->
//     out_valid=1 exactly 2 cycles later for 1 cycle, dout=8'hCC, out_sel=2.
//   3 Streaming: sel=0,1,2,3 on consecutive cycles, out_ready=1 -> dout=AA,BB,CC,DD
//     on 4 consecutive cycles starting 2 cycles after the first accept.
//   4 Backpressure: out_ready=0, in_valid held with sel=3,0,1 -> only 2 transfers
//     accepted, in_ready=0; raise out_ready -> DD, AA, then BB; no loss/dup.
//   5 Reset mid-stream: assert rst_n=0 with 2 transfers in flight -> out_valid=0
//     without a clock edge; after release, no stale data is emitted.
//   6 Scaling: N=8, WIDTH=16, din ch i = 16'h1000+i, sel=5 -> dout=16'h1005
//     3 cycles after accept; random valid/ready traffic checked against a reference FIFO model.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// Purpose: valid/ready bus bundle for mux_tree_pipe.
//   Input side : in_valid, in_ready, sel, din (N channels, WIDTH bits each, flattened)
//   Output side: out_valid, out_ready, dout, out_sel
//   master: producer/consumer side (testbench or surrounding datapath)
//   slave : the mux tree itself
interface mux_tree_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
);
  localparam int unsigned SEL_W = $clog2(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [SEL_W-1:0]     sel;
  logic [N*WIDTH-1:0]   din;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     dout;
  logic [SEL_W-1:0]     out_sel;

  modport master (
    output in_valid, sel, din, out_ready,
    input  in_ready, out_valid, dout, out_sel
  );

  modport slave (
    input  in_valid, sel, din, out_ready,
    output in_ready, out_valid, dout, out_sel
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Purpose: N:1 multiplexer built as a binary tree of 2:1 stages with a register
//   after every tree level and a valid/ready handshake on both ends.
//   One level per select bit (LSB resolves the first level), so an accepted
//   transfer reaches dout SEL_W cycles later; one transfer per cycle.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, synchronous release
//   bus    - mux_tree_pipe_if.slave: in_valid/in_ready/sel/din in,
//            out_valid/out_ready/dout/out_sel out (all outputs registered
//            except in_ready, which is the combinational ready chain)
module mux_tree_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_tree_pipe_if.slave bus
);

  localparam int unsigned SEL_W     = $clog2(N);
  localparam int unsigned LANES_ALL = N - 1;

  // All level registers packed back to back: level k occupies lanes
  // [N - (N>>k) .. N - (N>>(k+1)) - 1]; the final lane is the output.
  logic [LANES_ALL*WIDTH-1:0] data_all;
  logic [SEL_W*SEL_W-1:0]     sel_all;
  logic [SEL_W-1:0]           valid_all;
  logic [SEL_W-1:0]           adv;

  for (genvar k = 0; k < SEL_W; k++) begin : g_lvl
    localparam int unsigned LANES = N >> (k + 1);
    localparam int unsigned OFF   = N - (N >> k);

    logic [2*LANES*WIDTH-1:0] prev_data;
    logic                     prev_valid;
    logic [SEL_W-1:0]         prev_sel;
    logic [LANES*WIDTH-1:0]   mux_d;
    logic [LANES*WIDTH-1:0]   data_q;
    logic [SEL_W-1:0]         sel_q;
    logic                     valid_q;

    // Predecessor: the input port for the first level, else the level below.
    if (k == 0) begin : g_src
      assign prev_data  = bus.din;
      assign prev_valid = bus.in_valid;
      assign prev_sel   = bus.sel;
    end else begin : g_chain
      assign prev_data  = data_all[(N - (N >> (k - 1)))*WIDTH +: 2*LANES*WIDTH];
      assign prev_valid = valid_all[k-1];
      assign prev_sel   = sel_all[(k-1)*SEL_W +: SEL_W];
    end

    // A stage may load when any stage from here to the output has a hole,
    // or the consumer pops; written flat so adv never feeds back into itself.
    assign adv[k] = bus.out_ready | ~(&valid_all[SEL_W-1:k]);

    // 2:1 selection per lane, steered by this level's select bit.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign mux_d[j*WIDTH +: WIDTH] = prev_sel[k] ? prev_data[(2*j+1)*WIDTH +: WIDTH]
                                                   : prev_data[(2*j)*WIDTH +: WIDTH];
    end

    // Level register: load (bubbles included) on advance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        sel_q   <= '0;
        data_q  <= '0;
      end else if (adv[k]) begin
        valid_q <= prev_valid;
        sel_q   <= prev_sel;
        data_q  <= mux_d;
      end
    end

    assign valid_all[k]                    = valid_q;
    assign sel_all[k*SEL_W +: SEL_W]       = sel_q;
    assign data_all[OFF*WIDTH +: LANES*WIDTH] = data_q;
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = valid_all[SEL_W-1];
  assign bus.out_sel   = sel_all[(SEL_W-1)*SEL_W +: SEL_W];
  assign bus.dout      = data_all[(N-2)*WIDTH +: WIDTH];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Purpose: scoreboard bench for mux_tree_pipe. Two instances: N=4/WIDTH=8
//   (directed latency, streaming, backpressure and reset cases) and
//   N=8/WIDTH=16 (scaling plus random valid/ready traffic). Drivers push the
//   expected beat on every accepted transfer; per-instance monitors pop and
//   compare whenever a beat leaves the DUT.
module tb_mux_tree_pipe;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  sel;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  exp_t q4[$];
  exp_t q8[$];

  mux_tree_pipe_if #(.WIDTH(8),  .N(4)) b4 ();
  mux_tree_pipe_if #(.WIDTH(16), .N(8)) b8 ();

  mux_tree_pipe #(.WIDTH(8),  .N(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_tree_pipe #(.WIDTH(16), .N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One cycle on the 4-channel instance; inputs change just after the edge.
  task automatic drive4(input bit v, input logic [1:0] s, input logic [7:0] e,
                        input bit rdy, input bit lat, input bit push, output bit acc);
    @(posedge clk);
    #1;
    b4.in_valid  = v;
    b4.sel       = s;
    b4.out_ready = rdy;
    #1;
    acc = v && b4.in_ready;
    if (acc && push) q4.push_back('{16'(e), 3'(s), cyc, lat});
  endtask

  task automatic drive8(input bit v, input logic [2:0] s, input logic [127:0] d,
                        input logic [15:0] e, input bit rdy, input bit lat,
                        input bit push, output bit acc);
    @(posedge clk);
    #1;
    b8.in_valid  = v;
    b8.sel       = s;
    b8.din       = d;
    b8.out_ready = rdy;
    #1;
    acc = v && b8.in_ready;
    if (acc && push) q8.push_back('{e, s, cyc, lat});
  endtask

  task automatic drain4();
    bit acc;
    for (int i = 0; i < 30 && q4.size() != 0; i++) drive4(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
    chk("drain4_empty", 32'(q4.size()), 32'd0);
    repeat (3) drive4(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, acc);
  endtask

  task automatic drain8();
    bit acc;
    for (int i = 0; i < 60 && q8.size() != 0; i++)
      drive8(1'b0, 3'd0, 128'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
    chk("drain8_empty", 32'(q8.size()), 32'd0);
    repeat (3) drive8(1'b0, 3'd0, 128'h0, 16'h0, 1'b1, 1'b0, 1'b0, acc);
  endtask

  // Monitor for the 4-channel instance: pop/compare and stall stability.
  bit         hold4 = 1'b0;
  logic [7:0] held_d4;
  logic [1:0] held_s4;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold4 = 1'b0;
    end else begin
      if (hold4) begin
        chk("stall_valid4", 32'(b4.out_valid), 32'd1);
        chk("stall_dout4", 32'(b4.dout), 32'(held_d4));
        chk("stall_sel4", 32'(b4.out_sel), 32'(held_s4));
      end
      if (b4.out_valid && b4.out_ready) begin
        if (q4.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out4: got dout %0h, required no output (cycle %0d)", b4.dout, cyc);
        end else begin
          e = q4.pop_front();
          chk("dout4", 32'(b4.dout), 32'(e.data));
          chk("out_sel4", 32'(b4.out_sel), 32'(e.sel));
          if (e.lat) chk("latency4", 32'(cyc - e.acc), 32'd2);
        end
      end
      hold4   = b4.out_valid && !b4.out_ready;
      held_d4 = b4.dout;
      held_s4 = b4.out_sel;
    end
  end

  // Monitor for the 8-channel instance.
  bit          hold8 = 1'b0;
  logic [15:0] held_d8;
  logic [2:0]  held_s8;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        chk("stall_valid8", 32'(b8.out_valid), 32'd1);
        chk("stall_dout8", 32'(b8.dout), 32'(held_d8));
        chk("stall_sel8", 32'(b8.out_sel), 32'(held_s8));
      end
      if (b8.out_valid && b8.out_ready) begin
        if (q8.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out8: got dout %0h, required no output (cycle %0d)", b8.dout, cyc);
        end else begin
          e = q8.pop_front();
          chk("dout8", 32'(b8.dout), 32'(e.data));
          chk("out_sel8", 32'(b8.out_sel), 32'(e.sel));
          if (e.lat) chk("latency8", 32'(cyc - e.acc), 32'd3);
        end
      end
      hold8   = b8.out_valid && !b8.out_ready;
      held_d8 = b8.dout;
      held_s8 = b8.out_sel;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit           acc;
    logic [7:0]   stream_exp [4];
    logic [127:0] d8;
    logic [2:0]   s8;
    logic [15:0]  e8;
    int           tries;

    stream_exp[0] = 8'hAA;
    stream_exp[1] = 8'hBB;
    stream_exp[2] = 8'hCC;
    stream_exp[3] = 8'hDD;

    rst_n        = 1'b0;
    b4.in_valid  = 1'b0;
    b4.sel       = '0;
    b4.din       = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    b4.out_ready = 1'b0;
    b8.in_valid  = 1'b0;
    b8.sel       = '0;
    b8.din       = '0;
    b8.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("rst_dout4", 32'(b4.dout), 32'h00);
    chk("rst_out_sel4", 32'(b4.out_sel), 32'd0);
    chk("rst_out_valid8", 32'(b8.out_valid), 32'd0);
    chk("rst_dout8", 32'(b8.dout), 32'h0000);
    chk("rst_out_sel8", 32'(b8.out_sel), 32'd0);
    #19;
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready4", 32'(b4.in_ready), 32'd1);
    chk("post_rst_in_ready8", 32'(b8.in_ready), 32'd1);

    // Latency: single transfer, sel=2 -> CC two cycles later
    drive4(1'b1, 2'd2, 8'hCC, 1'b1, 1'b1, 1'b1, acc);
    chk("accept_single4", 32'(acc), 32'd1);
    drain4();

    // Streaming sel 0..3 back to back
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'(i), stream_exp[i], 1'b1, 1'b1, 1'b1, acc);
      chk("accept_stream4", 32'(acc), 32'd1);
    end
    drain4();

    // Backpressure: only two accepted while out_ready is low
    drive4(1'b1, 2'd3, 8'hDD, 1'b0, 1'b0, 1'b1, acc);
    chk("bp_accept_first", 32'(acc), 32'd1);
    drive4(1'b1, 2'd0, 8'hAA, 1'b0, 1'b0, 1'b1, acc);
    chk("bp_accept_second", 32'(acc), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'd1, 8'hBB, 1'b0, 1'b0, 1'b1, acc);
      chk("bp_full_in_ready", 32'(b4.in_ready), 32'd0);
    end
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 5) begin
      drive4(1'b1, 2'd1, 8'hBB, 1'b1, 1'b0, 1'b1, acc);
      tries++;
    end
    chk("bp_release_accept_cycles", 32'(tries), 32'd1);
    drain4();

    // Reset with two transfers in flight: output drops without a clock edge
    drive4(1'b1, 2'd1, 8'hBB, 1'b0, 1'b0, 1'b0, acc);
    drive4(1'b1, 2'd2, 8'hCC, 1'b0, 1'b0, 1'b0, acc);
    drive4(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
    chk("pre_rst_out_valid4", 32'(b4.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("async_rst_dout4", 32'(b4.dout), 32'h00);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (6) drive4(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, acc);

    // Scaling: N=8, WIDTH=16, channel i = 16'h1000+i, sel=5
    for (int i = 0; i < 8; i++) d8[i*16 +: 16] = 16'h1000 + 16'(i);
    drive8(1'b1, 3'd5, d8, 16'h1005, 1'b1, 1'b1, 1'b1, acc);
    chk("accept_scale8", 32'(acc), 32'd1);
    drain8();

    // Random valid/ready traffic against the reference FIFO
    for (int i = 0; i < 300; i++) begin
      d8 = {$urandom, $urandom, $urandom, $urandom};
      s8 = 3'($urandom_range(0, 7));
      e8 = 16'(d8 >> (32'(s8) * 16));
      drive8(($urandom_range(0, 2) != 0), s8, d8, e8, ($urandom_range(0, 3) != 0),
             1'b0, 1'b1, acc);
    end
    drain8();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
